// File: rtl/sram_port_arbiter.sv
//==============================================================================
// Module      : sram_port_arbiter
// Description : Two-port arbiter sharing one SRAM controller between the MEM
//               stage (port 0) and a secondary requester (port 1).
//               Optional macro SRAM_ARB_FIXED_PRIO_EN selects fixed priority
//               (port 0 always wins a tie) instead of round-robin.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sram_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_rd_en,
    input  logic              p0_wr_en,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ready,

    input  logic              p1_rd_en,
    input  logic              p1_wr_en,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ready,

    output logic              mc_rd_en,
    output logic              mc_wr_en,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_wdata,
    input  logic [DATA_W-1:0] mc_rdata,
    input  logic              mc_ready,

    output logic              owner,
    output logic              busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              state_q,    state_d;
    logic                owner_q,    owner_d;
    logic                mc_rd_en_q, mc_rd_en_d;
    logic                mc_wr_en_q, mc_wr_en_d;
    logic [ADDR_W-1:0]   mc_addr_q,  mc_addr_d;
    logic [DATA_W-1:0]   mc_wdata_q, mc_wdata_d;
    logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    // High when port 1 should win the next tie.
    logic                prio_q,     prio_d;
`endif

    logic                w_req0;
    logic                w_req1;
    logic                w_pick1;
    logic                w_sel_rd;
    logic                w_sel_wr;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_done;

    assign w_req0 = p0_rd_en | p0_wr_en;
    assign w_req1 = p1_rd_en | p1_wr_en;
    assign w_done = (state_q == ST_BUSY) && mc_ready;

    // Winner selection for the grant issued in IDLE.
    always_comb begin
        w_pick1 = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        w_pick1 = w_req1 && !w_req0;
`else
        w_pick1 = w_req1 && (!w_req0 || prio_q);
`endif
        if (w_pick1) begin
            w_sel_rd    = p1_rd_en;
            w_sel_wr    = p1_wr_en;
            w_sel_addr  = p1_addr;
            w_sel_wdata = p1_wdata;
        end else begin
            w_sel_rd    = p0_rd_en;
            w_sel_wr    = p0_wr_en;
            w_sel_addr  = p0_addr;
            w_sel_wdata = p0_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        mc_rd_en_d = mc_rd_en_q;
        mc_wr_en_d = mc_wr_en_q;
        mc_addr_d  = mc_addr_q;
        mc_wdata_d = mc_wdata_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        prio_d     = prio_q;
`endif
        case (state_q)
            ST_IDLE: begin
                mc_rd_en_d = 1'b0;
                mc_wr_en_d = 1'b0;
                if (w_req0 || w_req1) begin
                    owner_d    = w_pick1;
                    // A simultaneous read+write request is issued as a write.
                    mc_wr_en_d = w_sel_wr;
                    mc_rd_en_d = w_sel_rd && !w_sel_wr;
                    mc_addr_d  = w_sel_addr;
                    mc_wdata_d = w_sel_wdata;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Port inputs are ignored here; the latched access runs to completion.
                if (mc_ready) begin
                    if (mc_rd_en_q) begin
                        if (owner_q) begin
                            p1_rdata_d = mc_rdata;
                        end else begin
                            p0_rdata_d = mc_rdata;
                        end
                    end
                    mc_rd_en_d = 1'b0;
                    mc_wr_en_d = 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    prio_d     = !owner_q;
`endif
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                mc_rd_en_d = 1'b0;
                mc_wr_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            mc_rd_en_q <= 1'b0;
            mc_wr_en_q <= 1'b0;
            mc_addr_q  <= '0;
            mc_wdata_q <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            prio_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            mc_rd_en_q <= mc_rd_en_d;
            mc_wr_en_q <= mc_wr_en_d;
            mc_addr_q  <= mc_addr_d;
            mc_wdata_q <= mc_wdata_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            prio_q     <= prio_d;
`endif
        end
    end

    assign mc_rd_en = mc_rd_en_q;
    assign mc_wr_en = mc_wr_en_q;
    assign mc_addr  = mc_addr_q;
    assign mc_wdata = mc_wdata_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;
    assign owner    = owner_q;
    assign busy     = (state_q == ST_BUSY);

    // A port that is not requesting is never stalled.
    assign p0_ready = !w_req0 || (w_done && !owner_q);
    assign p1_ready = !w_req1 || (w_done &&  owner_q);

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
//==============================================================================
// Module      : tb_sram_port_arbiter
// Description : Directed self-checking bench for sram_port_arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sram_port_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              p0_rd_en = 1'b0, p0_wr_en = 1'b0;
    logic [ADDR_W-1:0] p0_addr = '0;
    logic [DATA_W-1:0] p0_wdata = '0;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_ready;
    logic              p1_rd_en = 1'b0, p1_wr_en = 1'b0;
    logic [ADDR_W-1:0] p1_addr = '0;
    logic [DATA_W-1:0] p1_wdata = '0;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_ready;
    logic              mc_rd_en, mc_wr_en;
    logic [ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0] mc_wdata;
    logic [DATA_W-1:0] mc_rdata = '0;
    logic              mc_ready = 1'b0;
    logic              owner, busy;

    int n_checks = 0;
    int n_errors = 0;

    sram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .p0_rd_en (p0_rd_en),
        .p0_wr_en (p0_wr_en),
        .p0_addr  (p0_addr),
        .p0_wdata (p0_wdata),
        .p0_rdata (p0_rdata),
        .p0_ready (p0_ready),
        .p1_rd_en (p1_rd_en),
        .p1_wr_en (p1_wr_en),
        .p1_addr  (p1_addr),
        .p1_wdata (p1_wdata),
        .p1_rdata (p1_rdata),
        .p1_ready (p1_ready),
        .mc_rd_en (mc_rd_en),
        .mc_wr_en (mc_wr_en),
        .mc_addr  (mc_addr),
        .mc_wdata (mc_wdata),
        .mc_rdata (mc_rdata),
        .mc_ready (mc_ready),
        .owner    (owner),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rd_wr_exclusive", {31'd0, mc_rd_en & mc_wr_en}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        #1;
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_rd_en",    {31'd0, mc_rd_en}, 32'd0);
        check("rst_wr_en",    {31'd0, mc_wr_en}, 32'd0);
        check("rst_addr",     mc_addr,           32'd0);
        check("rst_wdata",    mc_wdata,          32'd0);
        check("rst_p0_rdata", p0_rdata,          32'd0);
        check("rst_p1_rdata", p1_rdata,          32'd0);
        check("rst_owner",    {31'd0, owner},    32'd0);
        check("rst_p0_ready", {31'd0, p0_ready}, 32'd1);

        // Port 0 read with a 4-cycle controller latency.
        p0_rd_en = 1'b1; p0_addr = 32'h400; #1;
        check("t1_ready_req", {31'd0, p0_ready}, 32'd0);
        tick();
        check("t1_busy",  {31'd0, busy},     32'd1);
        check("t1_rd_en", {31'd0, mc_rd_en}, 32'd1);
        check("t1_addr",  mc_addr,           32'h400);
        check("t1_owner", {31'd0, owner},    32'd0);
        for (int i = 0; i < 3; i++) begin
            check("t1_p0_stall", {31'd0, p0_ready}, 32'd0);
            check("t1_p1_free",  {31'd0, p1_ready}, 32'd1);
            check("t1_addr_hold", mc_addr, 32'h400);
            tick();
        end
        mc_ready = 1'b1; mc_rdata = 32'hDEADBEEF; #1;
        check("t1_p0_ready_pulse", {31'd0, p0_ready}, 32'd1);
        check("t1_p1_free_done",   {31'd0, p1_ready}, 32'd1);
        tick();
        mc_ready = 1'b0; mc_rdata = '0; p0_rd_en = 1'b0; #1;
        check("t1_rdata", p0_rdata, 32'hDEADBEEF);
        check("t1_idle",  {31'd0, busy},     32'd0);
        check("t1_rd_clr", {31'd0, mc_rd_en}, 32'd0);
        // A completion pulse in IDLE must be ignored.
        mc_ready = 1'b1; mc_rdata = 32'h11111111;
        tick();
        mc_ready = 1'b0;
        check("idle_ready_busy",  {31'd0, busy}, 32'd0);
        check("idle_ready_rdata", p0_rdata, 32'hDEADBEEF);

        // Simultaneous port 0 write and port 1 read after reset.
        do_reset();
        p0_wr_en = 1'b1; p0_addr = 32'h10; p0_wdata = 32'h12345678;
        p1_rd_en = 1'b1; p1_addr = 32'h20; #1;
        check("t2_p0_stall", {31'd0, p0_ready}, 32'd0);
        check("t2_p1_stall", {31'd0, p1_ready}, 32'd0);
        tick();
        check("t2_owner0", {31'd0, owner},    32'd0);
        check("t2_wr_en",  {31'd0, mc_wr_en}, 32'd1);
        check("t2_addr0",  mc_addr,           32'h10);
        check("t2_wdata0", mc_wdata,          32'h12345678);
        check("t2_p1_wait", {31'd0, p1_ready}, 32'd0);
        mc_ready = 1'b1; mc_rdata = 32'h99999999; #1;
        check("t2_p0_done", {31'd0, p0_ready}, 32'd1);
        check("t2_p1_wait_done", {31'd0, p1_ready}, 32'd0);
        tick();
        mc_ready = 1'b0; p0_wr_en = 1'b0; #1;
        check("t2_idle_gap", {31'd0, busy},     32'd0);
        check("t2_wr_clr",   {31'd0, mc_wr_en}, 32'd0);
        check("t2_p0_rdata_keep", p0_rdata, 32'd0);
        tick();
        check("t2_owner1", {31'd0, owner},    32'd1);
        check("t2_rd_en1", {31'd0, mc_rd_en}, 32'd1);
        check("t2_addr1",  mc_addr,           32'h20);
        mc_ready = 1'b1; mc_rdata = 32'hCAFEF00D; #1;
        check("t2_p1_done", {31'd0, p1_ready}, 32'd1);
        tick();
        mc_ready = 1'b0; p1_rd_en = 1'b0; #1;
        check("t2_p1_rdata", p1_rdata, 32'hCAFEF00D);

        // Both ports requesting continuously for six accesses.
        p0_rd_en = 1'b1; p0_addr = 32'h100;
        p1_rd_en = 1'b1; p1_addr = 32'h200;
        tick();
        for (int k = 0; k < 6; k++) begin
            logic exp_own;
            exp_own = FIXED_PRIO ? 1'b0 : k[0];
            check("t3_owner", {31'd0, owner}, {31'd0, exp_own});
            check("t3_addr",  mc_addr, exp_own ? 32'h200 : 32'h100);
            mc_ready = 1'b1; mc_rdata = 32'h100 + k;
            tick();
            mc_ready = 1'b0; #1;
            check("t3_gap", {31'd0, busy}, 32'd0);
            check("t3_rdata", exp_own ? p1_rdata : p0_rdata, 32'h100 + k);
            tick();
        end
        p0_rd_en = 1'b0; p1_rd_en = 1'b0;
        mc_ready = 1'b1; mc_rdata = '0;
        tick();
        mc_ready = 1'b0;

        // Port 1 read+write together is a single write.
        do_reset();
        p1_rd_en = 1'b1; p1_wr_en = 1'b1; p1_addr = 32'h30; p1_wdata = 32'hA5A5A5A5;
        tick();
        check("t4_owner", {31'd0, owner},    32'd1);
        check("t4_wr_en", {31'd0, mc_wr_en}, 32'd1);
        check("t4_rd_en", {31'd0, mc_rd_en}, 32'd0);
        check("t4_addr",  mc_addr,           32'h30);
        check("t4_wdata", mc_wdata,          32'hA5A5A5A5);
        mc_ready = 1'b1; mc_rdata = 32'hFFFFFFFF;
        tick();
        mc_ready = 1'b0; p1_rd_en = 1'b0; p1_wr_en = 1'b0; #1;
        check("t4_p1_rdata", p1_rdata, 32'd0);
        check("t4_wr_clr", {31'd0, mc_wr_en}, 32'd0);

        // Reset two cycles into a port 1 read.
        p1_rd_en = 1'b1; p1_addr = 32'h44;
        tick();
        check("t5_busy", {31'd0, busy}, 32'd1);
        tick();
        rst = 1'b0; mc_ready = 1'b1; mc_rdata = 32'h77777777;
        tick();
        rst = 1'b1; mc_ready = 1'b0; p1_rd_en = 1'b0; #1;
        check("t5_rd_en", {31'd0, mc_rd_en}, 32'd0);
        check("t5_busy0", {31'd0, busy},     32'd0);
        check("t5_p1_rdata", p1_rdata,       32'd0);
        p0_rd_en = 1'b1; p0_addr = 32'h50;
        tick();
        check("t5_owner", {31'd0, owner},    32'd0);
        check("t5_rd_en0", {31'd0, mc_rd_en}, 32'd1);
        check("t5_addr",  mc_addr,           32'h50);
        mc_ready = 1'b1; mc_rdata = 32'h00005A5A;
        tick();
        mc_ready = 1'b0; p0_rd_en = 1'b0; #1;
        check("t5_p0_rdata", p0_rdata, 32'h00005A5A);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-port arbiter that shares the single SRAM memory controller between the pipeline's MEM stage (port 0) and a secondary requester (port 1, e.g. instruction-fetch refill or a debug/DMA port). It grants one requester at a time and drives the controller's read/write enables, address and write data from registers for the whole access. It returns read data and a per-port `ready` stall signal. It sits between the MEM stage and the memory controller, replacing the direct MEM-to-controller connection.

## Interface
- `DATA_W`, 32, data width of both ports and controller
- `ADDR_W`, 32, address width (byte address as produced by the ALU)

- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: synchronous, active-low reset
- `p0_rd_en`, `p0_wr_en` in 1: port 0 read/write request, level, held until `p0_ready`
- `p0_addr` in ADDR_W: port 0 address
- `p0_wdata` in DATA_W: port 0 write data
- `p0_rdata` out DATA_W: port 0 read data, registered
- `p0_ready` out 1: port 0 may advance; low = stall
- `p1_*`: identical set for port 1
- `mc_rd_en`, `mc_wr_en` out 1: controller enables, registered
- `mc_addr` out ADDR_W, `mc_wdata` out DATA_W: registered controller request
- `mc_rdata` in DATA_W: controller read data, valid in the `mc_ready` cycle
- `mc_ready` in 1: controller completion; sampled only in BUSY
- `owner` out 1: port currently or last granted
- `busy` out 1: high in BUSY

## Operation
- `req_i = pi_rd_en | pi_wr_en`. If both are set, write wins: `mc_wr_en=1`, `mc_rd_en=0`.
- States:
  - IDLE: if any `req_i`, pick a winner, latch its addr/wdata/op into `mc_*`, set `owner`, go to BUSY. Otherwise stay, with `mc_rd_en=mc_wr_en=0`.
  - BUSY: hold all `mc_*` stable. On `mc_ready=1`:
    - capture `mc_rdata` into `p<owner>_rdata` (reads only; writes leave it unchanged)
    - clear `mc_rd_en`/`mc_wr_en`
    - flip the priority pointer to the non-owner
    - go to IDLE
- Arbitration is round-robin:
  - the port not granted last wins a tie
  - a lone requester always wins
  - after reset the pointer favours port 0
- `pi_ready` is combinational: `!req_i || (busy && owner==i && mc_ready)`. A non-requesting port is never stalled.
- A request withdrawn or changed while granted is ignored. The latched access completes and rdata is still captured.
- `pi_rdata` holds its value until that port's next read completes.
- Reset values: state IDLE, `mc_rd_en=mc_wr_en=0`, `mc_addr=mc_wdata=0`, `p0_rdata=p1_rdata=0`, `owner=0`, pointer favours port 0, `busy=0`.
- Reset mid-access: the enables drop at the reset edge and no rdata is captured. The controller is reset on the same `rst`.

## Timing
- A request seen in IDLE at edge N drives `mc_*` valid from cycle N+1.
- For a grant issued in IDLE cycle N, the earliest completion is `mc_ready` in cycle N+1. The requester's `ready` rises in that same cycle.
- The return to IDLE costs one cycle. Back-to-back accesses have at least 1 IDLE cycle between `mc_*` assertions.
- A loser waits at most one full access plus 1 IDLE cycle before being granted (round-robin mode).
- A `mc_ready` pulse in IDLE is ignored.

## Configuration
- `SRAM_ARB_FIXED_PRIO_EN`:
  - Defined: port 0 wins every tie and the pointer is unused. Port 1 can starve under continuous port 0 traffic.
  - Undefined: round-robin as above.

## Test plan
- Port 0 read, addr 0x400; controller returns 0xDEADBEEF with `mc_ready` 4 cycles after grant.
  - `p0_ready` is low for 4 cycles and pulses high with `mc_ready`.
  - `p0_rdata=0xDEADBEEF` the next cycle.
  - `p1_ready` stays 1.
- Port 0 write (0x10, 0x12345678) and port 1 read (0x20) raised in the same cycle, after reset.
  - Port 0 is granted first; port 1 is granted in the cycle after IDLE.
  - `mc_wr_en` and `mc_rd_en` are never high together.
  - `p1_ready` is low throughout port 0's access.
- Both ports request continuously for 6 accesses: grants alternate 0,1,0,1,0,1. With `SRAM_ARB_FIXED_PRIO_EN` defined: 0,0,0,0,0,0.
- Port 1 asserts `rd_en` and `wr_en` together (0x30, 0xA5A5A5A5): a single write is issued and `p1_rdata` is unchanged.
- `rst=0` two cycles into a port 1 read: next cycle `mc_rd_en=0`, `busy=0`, `p1_rdata=0`. A port 0 request after release is granted normally.
